// File: rtl/lane_serializer_if.sv
// Handshake bundle for lane_serializer: a LANES-wide input word stream and a
// single-sample output stream carrying last-lane and saturation flags.
interface lane_serializer_if #(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 16
);
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic                        out_sat;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_sat
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_sat
  );
endinterface

// File: rtl/lane_serializer.sv
// Parallel-to-serial stage: takes one word of LANES signed samples and emits
// them oldest-first, one per cycle, with an optional saturating left shift.
module lane_serializer #(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 16,
  parameter int SHIFT      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  lane_serializer_if.slave bus
);
  localparam int WORD_W = LANES * DATA_WIDTH;
  localparam int IDX_W  = 2;
  localparam int EXT_W  = DATA_WIDTH + SHIFT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [IDX_W-1:0]      lane_idx_q, lane_idx_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_sat_q, out_sat_d;

  logic                    busy;
  logic                    on_last;
  logic                    in_ready;
  logic                    in_xfer;
  logic                    out_xfer;
  logic [DATA_WIDTH-1:0]   lane_sel;
  logic signed [EXT_W-1:0] shifted;
  logic [SHIFT:0]          head;

  assign busy    = (state_q == EMIT);
  assign on_last = (lane_idx_q == LAST_IDX);

  // Gated by reset so the upstream never sees a ready while the block is held.
  assign in_ready = reset & en & (~busy | (on_last & bus.out_ready));
  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = en & busy & bus.out_ready;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    lane_idx_d = lane_idx_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          word_d     = bus.in_data;
          lane_idx_d = '0;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (!on_last) begin
            lane_idx_d = lane_idx_q + 1'b1;
          end else if (in_xfer) begin
            word_d     = bus.in_data;
            lane_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output sample is computed from the next state and registered, so it only
  // moves when the lane pointer or the word actually changes.
  always_comb begin
    lane_sel = word_d[DATA_WIDTH-1:0];
    for (int k = 1; k < LANES; k++) begin
      if (lane_idx_d == IDX_W'(k)) lane_sel = word_d[k*DATA_WIDTH +: DATA_WIDTH];
    end

    shifted = EXT_W'(signed'(lane_sel)) <<< SHIFT;

    // The result fits iff the bits above the output sign bit are all copies of it.
    head      = shifted[EXT_W-1:DATA_WIDTH-1];
    out_sat_d = !((head == '0) || (head == '1));
    if (!out_sat_d) begin
      out_data_d = shifted[DATA_WIDTH-1:0];
    end else if (shifted[EXT_W-1]) begin
      out_data_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      out_data_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    out_last_d = (state_d == EMIT) && (lane_idx_d == LAST_IDX);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of ordering.
  // NOTE: word_q is a plain register feeding out_data, so it is reset along
  // with the rest to give a defined 0 output straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      lane_idx_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      lane_idx_q <= lane_idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = busy;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sat   = out_sat_q;

endmodule
